ddr_pixel_pack: RTL and testbench
=================================

DDR_PIXEL_PACK -- requirements
Module: ddr_pixel_pack

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of one D2Q9 distribution value.
REQ-002 Parameter DEPTH, default 2500: pixels per frame.
REQ-003 Parameter ADDRESS_WIDTH, default 12: width of the pixel index.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 m00_axis_aclk  in  1  sole clock; all logic on its rising edge.
REQ-006 m00_axis_areset  in  1  synchronous, active-high reset.
REQ-007 n_in, null_in, ne_in, e_in, se_in, s_in, sw_in, w_in, nw_in  in  DATA_WIDTH each  post-collision distributions of one pixel.
REQ-008 pix_valid  in  1  the nine inputs hold a valid pixel.
REQ-009 pix_ready  out  1  block can accept a pixel this cycle.
REQ-010 m00_axis_tdata  out  9*DATA_WIDTH  packed pixel beat.
REQ-011 m00_axis_tvalid  out  1  beat valid.
REQ-012 m00_axis_tready  in  1  downstream accepts beat.
REQ-013 m00_axis_tlast  out  1  beat is the last pixel of the frame.
REQ-014 m00_axis_tstrb  out  9*DATA_WIDTH/8  byte strobes.
REQ-015 pix_index  out  ADDRESS_WIDTH  index of the pixel in the output register.
REQ-016 frame_done  out  1  one-cycle pulse on frame completion.

Function
REQ-017 Packing SHALL be n [15:0], null [31:16], ne [47:32], e [63:48], se [79:64], s [95:80], sw [111:96], w [127:112], nw [143:128], scaled by DATA_WIDTH.
REQ-018 m00_axis_tstrb SHALL be all ones at all times.
REQ-019 A pixel is accepted when pix_valid && pix_ready; a beat is transferred when m00_axis_tvalid && m00_axis_tready.
REQ-020 Buffering SHALL be a 2-entry skid buffer with states EMPTY (0 held), ONE (1 held) and FULL (2 held).
REQ-021 Transitions: EMPTY->ONE on accept; ONE->FULL on accept without transfer; ONE->EMPTY on transfer without accept; ONE->ONE on accept and transfer in the same cycle; FULL->ONE on transfer; no other changes.
REQ-022 pix_ready SHALL be registered and equal (state != FULL); it SHALL NOT depend combinationally on m00_axis_tready.
REQ-023 m00_axis_tvalid SHALL equal (state != EMPTY); tdata, tlast and pix_index SHALL remain stable while tvalid && !tready.
REQ-024 Latency: a pixel accepted on cycle N into an EMPTY buffer SHALL appear with tvalid high on cycle N+1.
REQ-025 Beat order SHALL equal acceptance order; no pixel is dropped or duplicated.
REQ-026 A pixel counter SHALL increment on each accept and wrap from DEPTH-1 to 0; each beat carries its counter value in pix_index.
REQ-027 tlast SHALL be 1 only on the beat whose pix_index == DEPTH-1.
REQ-028 frame_done SHALL pulse for one cycle after the tlast beat transfers.
REQ-029 Simultaneous accept and transfer in state FULL SHALL NOT occur, because pix_ready is 0.

Reset
REQ-030 On reset: state EMPTY, tvalid 0, pix_ready 1 on the first cycle after reset, tlast 0, tdata 0, pix_index 0, counter 0, frame_done 0.
REQ-031 Reset mid-frame SHALL discard held beats and restart the counter at 0 without emitting tlast.

Structure
REQ-032 A shared package SHALL hold the D2Q9 direction slice offsets (N..NW), the skid-buffer state encodings, and the default DEPTH/DATA_WIDTH constants.
REQ-033 The skid buffer SHALL be one sub-module, axis_skid_buf, parameterised by payload width (tdata + tlast + pix_index); ddr_pixel_pack SHALL hold the pack and counter logic.

Verification
REQ-034 Packing: n=0x0001 ... nw=0x0009, tready=1 -> tdata = 0x0009_0008_..._0001 one cycle later, tstrb=0x3FFFF.
REQ-035 Backpressure: tready=0; offer 3 pixels -> 2 accepted, pix_ready 0 from the following cycle; raise tready -> 2 beats in order, tdata stable while stalled.
REQ-036 Frame: stream 2500 pixels with tready=1 -> tlast only on beat 2499, frame_done pulses once, pixel 2500 has pix_index 0.
REQ-037 Throughput: continuous pix_valid and tready -> one beat per cycle, state stays ONE, no bubbles.
REQ-038 Reset mid-frame: areset asserted at pixel 1200 with FULL buffer -> tvalid 0 next cycle, next accepted pixel has pix_index 0.
REQ-039 Random valid/ready: 10000 pixels -> scoreboard matches order and content; tlast every 2500th beat.

Source files
------------

// File: rtl/ddr_pixel_pack_pkg.sv
// Shared constants for the D2Q9 pixel packer: direction slice order,
// skid-buffer state encodings and default geometry.
package ddr_pixel_pack_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 16;
    localparam int DEFAULT_DEPTH         = 2500;
    localparam int DEFAULT_ADDRESS_WIDTH = 12;

    // Slot of each D2Q9 direction inside the packed beat, lowest slot first.
    localparam int DIR_N     = 0;
    localparam int DIR_NULL  = 1;
    localparam int DIR_NE    = 2;
    localparam int DIR_E     = 3;
    localparam int DIR_SE    = 4;
    localparam int DIR_S     = 5;
    localparam int DIR_SW    = 6;
    localparam int DIR_W     = 7;
    localparam int DIR_NW    = 8;
    localparam int DIR_COUNT = 9;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    function automatic int dir_lsb(input int dir, input int data_width);
        return dir * data_width;
    endfunction

endpackage

// File: rtl/ddr_pixel_pack_if.sv
// AXI-Stream style output bundle of the pixel packer, carrying the pixel
// index alongside the usual tdata/tlast/tstrb.
interface ddr_pixel_pack_if
    import ddr_pixel_pack_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
);
    logic [DIR_COUNT*DATA_WIDTH-1:0]   tdata;
    logic                              tvalid;
    logic                              tready;
    logic                              tlast;
    logic [DIR_COUNT*DATA_WIDTH/8-1:0] tstrb;
    logic [ADDRESS_WIDTH-1:0]          pix_index;

    modport master (
        output tdata, tvalid, tlast, tstrb, pix_index,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tstrb, pix_index,
        output tready
    );
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer: the output register holds the head beat, the skid
// register catches one extra beat so the upstream ready can be registered.
module axis_skid_buf
    import ddr_pixel_pack_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             m00_axis_aclk,
    input  logic             m00_axis_areset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);
    skid_state_t      state_q;
    skid_state_t      state_d;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             transfer;
    logic             load_out;
    logic             load_out_from_skid;
    logic             load_skid;

    assign accept   = s_valid && s_ready;
    assign transfer = m_valid && m_ready;
    assign m_valid  = (state_q != SKID_EMPTY);

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            state_q <= SKID_EMPTY;
            s_ready <= 1'b1;
        end else begin
            state_q <= state_d;
            s_ready <= (state_d != SKID_FULL);
        end
    end

    // Accept in FULL cannot happen because s_ready is already low there.
    always_comb begin
        state_d            = state_q;
        load_out           = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    state_d  = SKID_ONE;
                    load_out = 1'b1;
                end
            end
            SKID_ONE: begin
                case ({accept, transfer})
                    2'b10: begin
                        state_d   = SKID_FULL;
                        load_skid = 1'b1;
                    end
                    2'b01: state_d  = SKID_EMPTY;
                    2'b11: load_out = 1'b1;
                    default: ;
                endcase
            end
            SKID_FULL: begin
                if (transfer) begin
                    state_d            = SKID_ONE;
                    load_out_from_skid = 1'b1;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            m_data    <= '0;
            skid_data <= '0;
        end else begin
            if (load_out) begin
                m_data <= s_data;
            end else if (load_out_from_skid) begin
                m_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= s_data;
            end
        end
    end

endmodule

// File: rtl/ddr_pixel_pack.sv
// Packs the nine D2Q9 distributions of one pixel into a single stream beat,
// tagging it with its frame index and marking the last pixel of each frame.
module ddr_pixel_pack
    import ddr_pixel_pack_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                  m00_axis_aclk,
    input  logic                  m00_axis_areset,
    input  logic [DATA_WIDTH-1:0] n_in,
    input  logic [DATA_WIDTH-1:0] null_in,
    input  logic [DATA_WIDTH-1:0] ne_in,
    input  logic [DATA_WIDTH-1:0] e_in,
    input  logic [DATA_WIDTH-1:0] se_in,
    input  logic [DATA_WIDTH-1:0] s_in,
    input  logic [DATA_WIDTH-1:0] sw_in,
    input  logic [DATA_WIDTH-1:0] w_in,
    input  logic [DATA_WIDTH-1:0] nw_in,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    ddr_pixel_pack_if.master      m00_axis,
    output logic                  frame_done
);
    localparam int PIXEL_WIDTH   = DIR_COUNT * DATA_WIDTH;
    localparam int PAYLOAD_WIDTH = ADDRESS_WIDTH + 1 + PIXEL_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = ADDRESS_WIDTH'(DEPTH - 1);

    logic [PIXEL_WIDTH-1:0]   pixel_word;
    logic [ADDRESS_WIDTH-1:0] pix_count;
    logic                     accept;
    logic [PAYLOAD_WIDTH-1:0] in_payload;
    logic [PAYLOAD_WIDTH-1:0] out_payload;

    assign accept = pix_valid && pix_ready;

    always_comb begin
        pixel_word = '0;
        pixel_word[dir_lsb(DIR_N,    DATA_WIDTH) +: DATA_WIDTH] = n_in;
        pixel_word[dir_lsb(DIR_NULL, DATA_WIDTH) +: DATA_WIDTH] = null_in;
        pixel_word[dir_lsb(DIR_NE,   DATA_WIDTH) +: DATA_WIDTH] = ne_in;
        pixel_word[dir_lsb(DIR_E,    DATA_WIDTH) +: DATA_WIDTH] = e_in;
        pixel_word[dir_lsb(DIR_SE,   DATA_WIDTH) +: DATA_WIDTH] = se_in;
        pixel_word[dir_lsb(DIR_S,    DATA_WIDTH) +: DATA_WIDTH] = s_in;
        pixel_word[dir_lsb(DIR_SW,   DATA_WIDTH) +: DATA_WIDTH] = sw_in;
        pixel_word[dir_lsb(DIR_W,    DATA_WIDTH) +: DATA_WIDTH] = w_in;
        pixel_word[dir_lsb(DIR_NW,   DATA_WIDTH) +: DATA_WIDTH] = nw_in;
    end

    // Index and tlast are decided at accept time so they travel with the pixel.
    assign in_payload = {pix_count, (pix_count == LAST_INDEX), pixel_word};

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            pix_count <= '0;
        end else if (accept) begin
            pix_count <= (pix_count == LAST_INDEX) ? '0 : pix_count + 1'b1;
        end
    end

    axis_skid_buf #(
        .WIDTH (PAYLOAD_WIDTH)
    ) u_skid (
        .m00_axis_aclk   (m00_axis_aclk),
        .m00_axis_areset (m00_axis_areset),
        .s_data          (in_payload),
        .s_valid         (pix_valid),
        .s_ready         (pix_ready),
        .m_data          (out_payload),
        .m_valid         (m00_axis.tvalid),
        .m_ready         (m00_axis.tready)
    );

    assign m00_axis.tdata     = out_payload[PIXEL_WIDTH-1:0];
    assign m00_axis.tlast     = out_payload[PIXEL_WIDTH];
    assign m00_axis.pix_index = out_payload[PAYLOAD_WIDTH-1:PIXEL_WIDTH+1];
    assign m00_axis.tstrb     = '1;

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= m00_axis.tvalid && m00_axis.tready && m00_axis.tlast;
        end
    end

endmodule

// File: tb/tb_ddr_pixel_pack.sv
// Directed and randomised checks of ddr_pixel_pack against a queue model of
// the accepted pixels and an independent frame counter.
module tb_ddr_pixel_pack;

    localparam int DW    = 16;
    localparam int DEPTH = 2500;
    localparam int AW    = 12;
    localparam int TW    = 9 * DW;

    logic          clk;
    logic          rst;
    logic [DW-1:0] dir_val [9];
    logic          pix_valid;
    logic          pix_ready;
    logic          frame_done;

    logic [TW-1:0] exp_data_q [$];
    int            exp_idx_q  [$];
    int            model_cnt;
    int            tests;
    int            fails;
    int            beats;
    int            accepts;
    int            tlast_seen;
    int            frame_pulses;

    ddr_pixel_pack_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) m00_axis ();

    ddr_pixel_pack #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .m00_axis_aclk   (clk),
        .m00_axis_areset (rst),
        .n_in            (dir_val[0]),
        .null_in         (dir_val[1]),
        .ne_in           (dir_val[2]),
        .e_in            (dir_val[3]),
        .se_in           (dir_val[4]),
        .s_in            (dir_val[5]),
        .sw_in           (dir_val[6]),
        .w_in            (dir_val[7]),
        .nw_in           (dir_val[8]),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .m00_axis        (m00_axis),
        .frame_done      (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [159:0] actual, input logic [159:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [TW-1:0] packPixel();
        return {dir_val[8], dir_val[7], dir_val[6], dir_val[5], dir_val[4],
                dir_val[3], dir_val[2], dir_val[1], dir_val[0]};
    endfunction

    task automatic applyStimulus(input logic valid, input logic ready, input logic [15:0] base);
        pix_valid       = valid;
        m00_axis.tready = ready;
        for (int d = 0; d < 9; d++) dir_val[d] = base + 16'(d);
    endtask

    // One clock: record handshakes seen before the edge, then check outputs after it.
    task automatic stepCycle();
        logic acc;
        logic xfer;
        logic last_xfer;
        acc       = pix_valid && pix_ready;
        xfer      = m00_axis.tvalid && m00_axis.tready;
        last_xfer = 1'b0;
        if (xfer) begin
            beats++;
            if (m00_axis.tlast) tlast_seen++;
            if (exp_idx_q.size() != 0) begin
                last_xfer = (exp_idx_q[0] == DEPTH - 1);
                void'(exp_data_q.pop_front());
                void'(exp_idx_q.pop_front());
            end
        end
        if (acc) begin
            accepts++;
            exp_data_q.push_back(packPixel());
            exp_idx_q.push_back(model_cnt);
            model_cnt = (model_cnt == DEPTH - 1) ? 0 : model_cnt + 1;
        end
        @(posedge clk);
        #1;
        if (frame_done) frame_pulses++;
        checkOutput("tvalid", 160'(m00_axis.tvalid), 160'(exp_data_q.size() != 0));
        checkOutput("pix_ready", 160'(pix_ready), 160'(exp_data_q.size() < 2));
        checkOutput("frame_done", 160'(frame_done), 160'(last_xfer));
        checkOutput("tstrb", 160'(m00_axis.tstrb), 160'(18'h3FFFF));
        if (m00_axis.tvalid && exp_data_q.size() != 0) begin
            checkOutput("tdata", 160'(m00_axis.tdata), 160'(exp_data_q[0]));
            checkOutput("pix_index", 160'(m00_axis.pix_index), 160'(exp_idx_q[0]));
            checkOutput("tlast", 160'(m00_axis.tlast), 160'(exp_idx_q[0] == DEPTH - 1));
        end
    endtask

    task automatic doReset();
        rst       = 1'b1;
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_data_q.delete();
        exp_idx_q.delete();
        model_cnt = 0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        int guard;
        tests = 0; fails = 0; beats = 0; accepts = 0; tlast_seen = 0; frame_pulses = 0;
        model_cnt = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        doReset();

        checkOutput("rst_tvalid", 160'(m00_axis.tvalid), 160'(1'b0));
        checkOutput("rst_pix_ready", 160'(pix_ready), 160'(1'b1));
        checkOutput("rst_tlast", 160'(m00_axis.tlast), 160'(1'b0));
        checkOutput("rst_tdata", 160'(m00_axis.tdata), 160'(0));
        checkOutput("rst_pix_index", 160'(m00_axis.pix_index), 160'(0));
        checkOutput("rst_frame_done", 160'(frame_done), 160'(1'b0));

        // Packing order with n=1 .. nw=9
        applyStimulus(1'b1, 1'b1, 16'h0001);
        stepCycle();
        checkOutput("pack_tvalid", 160'(m00_axis.tvalid), 160'(1'b1));
        checkOutput("pack_tdata", 160'(m00_axis.tdata),
                    160'(144'h0009_0008_0007_0006_0005_0004_0003_0002_0001));
        checkOutput("pack_tstrb", 160'(m00_axis.tstrb), 160'(18'h3FFFF));
        applyStimulus(1'b0, 1'b1, 16'h0000);
        stepCycle();

        // Backpressure: three offers, two fit
        applyStimulus(1'b1, 1'b0, 16'h0A00);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 16'h0B00);
        stepCycle();
        checkOutput("bp_ready_low", 160'(pix_ready), 160'(1'b0));
        applyStimulus(1'b1, 1'b0, 16'h0C00);
        stepCycle();
        checkOutput("bp_head_held", 160'(m00_axis.tdata[15:0]), 160'(16'h0A00));
        checkOutput("bp_head_index", 160'(m00_axis.pix_index), 160'(1));
        beats = 0;
        applyStimulus(1'b0, 1'b1, 16'h0000);
        repeat (3) stepCycle();
        checkOutput("bp_beats", 160'(beats), 160'(2));

        // Full frame plus one pixel at full throughput
        doReset();
        beats = 0; tlast_seen = 0; frame_pulses = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus(1'b1, 1'b1, 16'(i));
            stepCycle();
        end
        applyStimulus(1'b0, 1'b1, 16'h0000);
        repeat (2) stepCycle();
        checkOutput("frame_beats", 160'(beats), 160'(DEPTH + 1));
        checkOutput("frame_tlast_count", 160'(tlast_seen), 160'(1));
        checkOutput("frame_done_count", 160'(frame_pulses), 160'(1));

        // Reset mid-frame with both entries held
        doReset();
        for (int i = 0; i < 1200; i++) begin
            applyStimulus(1'b1, 1'b1, 16'(i));
            stepCycle();
        end
        applyStimulus(1'b1, 1'b0, 16'h4000);
        stepCycle();
        checkOutput("mid_full_ready", 160'(pix_ready), 160'(1'b0));
        checkOutput("mid_head_index", 160'(m00_axis.pix_index), 160'(1199));
        doReset();
        checkOutput("mid_rst_tvalid", 160'(m00_axis.tvalid), 160'(1'b0));
        applyStimulus(1'b1, 1'b0, 16'h5000);
        stepCycle();
        checkOutput("mid_first_index", 160'(m00_axis.pix_index), 160'(0));
        checkOutput("mid_first_tlast", 160'(m00_axis.tlast), 160'(1'b0));
        applyStimulus(1'b0, 1'b1, 16'h0000);
        repeat (2) stepCycle();

        // Random valid/ready over four frames
        doReset();
        beats = 0; accepts = 0; tlast_seen = 0; frame_pulses = 0;
        cyc = 0;
        while (accepts < 4 * DEPTH && cyc < 60000) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 16'($urandom));
            stepCycle();
            cyc++;
        end
        checkOutput("rand_accepts", 160'(accepts), 160'(4 * DEPTH));
        applyStimulus(1'b0, 1'b1, 16'h0000);
        guard = 0;
        while (m00_axis.tvalid && guard < 10) begin
            stepCycle();
            guard++;
        end
        stepCycle();
        checkOutput("rand_beats", 160'(beats), 160'(4 * DEPTH));
        checkOutput("rand_tlast_count", 160'(tlast_seen), 160'(4));
        checkOutput("rand_frame_done_count", 160'(frame_pulses), 160'(4));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
